hazard_scoreboard: RTL and testbench

Parametrised successor to the fixed bypass/stall pair. It keeps an internal shadow of every in-flight register write across NSTAGE post-ID stages and derives per-operand forward selects and data stalls from per-instruction result-ready stages, instead of hard-coded load/CP0/branch cases. A small FSM sequences whole-pipe holds, exception flush and dcache drain, and a watchdog counts consecutive hold cycles. It sits beside the ID stage and drives all pipeline register write enables.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_src_check.sv | 32 +++
 rtl/hazard_scoreboard.sv | 138 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and stage numbering for the hazard scoreboard
package hazard_pkg;

  localparam int STG_EX   = 1;
  localparam int STG_MEM1 = 2;
  localparam int STG_MEM2 = 3;
  localparam int STG_WB   = 4;

  localparam int DEF_REGW = 5;
  localparam int DEF_SELW = $clog2(STG_WB + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic                vld;
    logic [DEF_REGW-1:0] rd;
    logic [DEF_SELW-1:0] rdy;
  } shadow_t;

endpackage

// File: rtl/hazard_src_check.sv
// rtl/hazard_src_check.sv - one operand: youngest in-flight match, forward select, readiness
module hazard_src_check
  import hazard_pkg::*;
#(
  parameter int NSTAGE = STG_WB,
  parameter int REGW   = DEF_REGW,
  parameter int SELW   = DEF_SELW
) (
  input  logic [NSTAGE-1:0]      i_vld,
  input  logic [NSTAGE*REGW-1:0] i_rd,
  input  logic [NSTAGE*SELW-1:0] i_rdy,
  input  logic [REGW-1:0]        i_src,
  input  logic                   i_used,
  input  logic                   i_late,
  output logic [SELW-1:0]        o_fwd_sel,
  output logic                   o_stall
);

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    o_fwd_sel = '0;
    o_stall   = 1'b0;
    for (int k = NSTAGE; k >= STG_EX; k--) begin
      if (i_vld[k-1] && i_used && (i_src != '0) && (i_rd[(k-1)*REGW +: REGW] == i_src)) begin
        o_fwd_sel = SELW'(k);
        o_stall   = ({1'b0, SELW'(k)} <
                     ({1'b0, i_rdy[(k-1)*SELW +: SELW]} + {{SELW{1'b0}}, ~i_late}));
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight write shadow, forward selects, stall/hold/flush sequencing
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSTAGE = STG_WB,
  parameter int NSRC   = 2,
  parameter int REGW   = DEF_REGW,
  parameter int CNTW   = 8,
  parameter int SELW   = $clog2(NSTAGE + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_id_valid,
  input  logic                   i_id_rfwr,
  input  logic [REGW-1:0]        i_id_rd,
  input  logic [SELW-1:0]        i_id_rdy_stg,
  input  logic [NSRC*REGW-1:0]   i_id_src,
  input  logic [NSRC-1:0]        i_id_src_used,
  input  logic [NSRC-1:0]        i_id_src_late,
  input  logic                   i_ext_stall,
  input  logic                   i_whole_req,
  input  logic                   i_exc_req,
  input  logic [NSTAGE-1:0]      i_exc_kill,
  input  logic                   i_dcache_ok,
  output logic                   o_pc_wr,
  output logic                   o_if_id_wr,
  output logic                   o_id_ex_wr,
  output logic [NSTAGE-2:0]      o_stage_wr,
  output logic                   o_bubble,
  output logic [NSRC*SELW-1:0]   o_fwd_sel,
  output logic                   o_data_stall,
  output logic                   o_whole_stall,
  output logic                   o_stall_timeout
);

  shadow_t                r_sh [STG_EX:NSTAGE];
  hz_state_e              r_state;
  hz_state_e              w_state_nxt;
  logic [CNTW-1:0]        r_cnt;
  logic [NSTAGE-1:0]      w_vld;
  logic [NSTAGE*REGW-1:0] w_rd;
  logic [NSTAGE*SELW-1:0] w_rdy;
  logic [NSRC-1:0]        w_src_stall;
  logic                   w_upd1;
  logic                   w_shift;
  logic                   w_kill;
  shadow_t                w_new1;

  for (genvar k = STG_EX; k <= NSTAGE; k++) begin : g_flat
    assign w_vld[k-1]                = r_sh[k].vld;
    assign w_rd[(k-1)*REGW +: REGW]  = r_sh[k].rd;
    assign w_rdy[(k-1)*SELW +: SELW] = r_sh[k].rdy;
  end

  for (genvar j = 0; j < NSRC; j++) begin : g_src
    hazard_src_check #(.NSTAGE(NSTAGE), .REGW(REGW), .SELW(SELW)) u_chk (
      .i_vld     (w_vld),
      .i_rd      (w_rd),
      .i_rdy     (w_rdy),
      .i_src     (i_id_src[j*REGW +: REGW]),
      .i_used    (i_id_src_used[j]),
      .i_late    (i_id_src_late[j]),
      .o_fwd_sel (o_fwd_sel[j*SELW +: SELW]),
      .o_stall   (w_src_stall[j])
    );
  end

  assign o_data_stall    = i_id_valid & ((|w_src_stall) | i_ext_stall);
  assign o_whole_stall   = ~o_id_ex_wr;
  assign o_stall_timeout = (r_cnt == '1);

  // A HOLD cycle whose whole_req has dropped falls through to the RUN rules.
  always_comb begin
    w_state_nxt = r_state;
    o_pc_wr     = 1'b0;
    o_if_id_wr  = 1'b0;
    o_id_ex_wr  = 1'b0;
    o_stage_wr  = '0;
    o_bubble    = 1'b0;
    w_upd1      = 1'b0;
    w_shift     = 1'b0;
    w_kill      = 1'b0;
    w_new1      = '0;
    if (i_exc_req) begin
      o_pc_wr     = 1'b1;
      o_if_id_wr  = 1'b1;
      o_id_ex_wr  = 1'b1;
      o_stage_wr  = {(NSTAGE-1){i_dcache_ok}};
      w_upd1      = 1'b1;
      w_shift     = i_dcache_ok;
      w_kill      = 1'b1;
      w_state_nxt = i_dcache_ok ? ST_RUN : ST_DRAIN;
    end else if (r_state == ST_DRAIN) begin
      if (i_dcache_ok) begin
        o_stage_wr  = '1;
        w_upd1      = 1'b1;
        w_shift     = 1'b1;
        w_state_nxt = ST_RUN;
      end
    end else if (i_whole_req) begin
      w_state_nxt = ST_HOLD;
    end else begin
      w_state_nxt = ST_RUN;
      o_id_ex_wr  = 1'b1;
      o_stage_wr  = '1;
      w_upd1      = 1'b1;
      w_shift     = 1'b1;
      if (o_data_stall) begin
        o_bubble = 1'b1;
      end else begin
        o_pc_wr    = 1'b1;
        o_if_id_wr = 1'b1;
        w_new1.vld = i_id_valid & i_id_rfwr & (i_id_rd != '0);
        w_new1.rd  = i_id_rd;
        w_new1.rdy = i_id_rdy_stg;
      end
    end
  end

  // Kill bits index the stage an entry occupied before this cycle's shift.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = STG_EX; k <= NSTAGE; k++) r_sh[k] <= '0;
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_RUN)  r_cnt <= '0;
      else if (r_cnt != '1)   r_cnt <= r_cnt + 1'b1;
      if (w_upd1) r_sh[STG_EX] <= w_new1;
      for (int k = STG_MEM1; k <= NSTAGE; k++) begin
        if (w_shift)                         r_sh[k] <= (w_kill && i_exc_kill[k-2]) ? '0 : r_sh[k-1];
        else if (w_kill && i_exc_kill[k-1])  r_sh[k] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed checks against an in-flight list model
module tb_hazard_scoreboard;

  localparam int K_EXC = 0, K_DGO = 1, K_DWAIT = 2, K_FREEZE = 3, K_BUB = 4, K_NORM = 5;

  typedef struct {
    int rd;
    int rdy;
    int stg;
  } inf_t;

  logic        clk, rst_n;
  logic        id_valid, id_rfwr;
  logic [4:0]  id_rd;
  logic [2:0]  id_rdy;
  logic [9:0]  id_src;
  logic [1:0]  used, late;
  logic        ext, whole, exc, dok;
  logic [3:0]  kill;
  logic        o_pc_wr, o_if_id_wr, o_id_ex_wr, o_bubble;
  logic [2:0]  o_stage_wr;
  logic [5:0]  o_fwd_sel;
  logic        o_data_stall, o_whole_stall, o_stall_timeout;
  logic [15:0] obs, exp;

  inf_t q[$];
  int   m_mode, m_cnt, e_kind;
  int   n_cmp, n_bad;

  hazard_scoreboard #(.NSTAGE(4), .NSRC(2), .REGW(5), .CNTW(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_rfwr(id_rfwr),
    .i_id_rd(id_rd), .i_id_rdy_stg(id_rdy), .i_id_src(id_src), .i_id_src_used(used),
    .i_id_src_late(late), .i_ext_stall(ext), .i_whole_req(whole), .i_exc_req(exc),
    .i_exc_kill(kill), .i_dcache_ok(dok), .o_pc_wr(o_pc_wr), .o_if_id_wr(o_if_id_wr),
    .o_id_ex_wr(o_id_ex_wr), .o_stage_wr(o_stage_wr), .o_bubble(o_bubble),
    .o_fwd_sel(o_fwd_sel), .o_data_stall(o_data_stall), .o_whole_stall(o_whole_stall),
    .o_stall_timeout(o_stall_timeout)
  );

  assign obs = {o_pc_wr, o_if_id_wr, o_id_ex_wr, o_stage_wr, o_bubble, o_fwd_sel,
                o_data_stall, o_whole_stall, o_stall_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_mode = 0;
    m_cnt  = 0;
  endtask

  task automatic model_eval();
    logic [2:0] f [2];
    logic st, ds;
    logic [6:0] en;
    st = 1'b0;
    for (int j = 0; j < 2; j++) begin
      int s, best, brdy;
      s = int'(id_src[j*5 +: 5]);
      best = 0;
      brdy = 0;
      foreach (q[i])
        if (q[i].rd == s && s != 0 && used[j] && (best == 0 || q[i].stg < best)) begin
          best = q[i].stg;
          brdy = q[i].rdy;
        end
      f[j] = 3'(best);
      if (best != 0 && best < brdy + (late[j] ? 0 : 1)) st = 1'b1;
    end
    ds = id_valid && (st || ext);
    if (exc)               e_kind = K_EXC;
    else if (m_mode == 2)  e_kind = dok ? K_DGO : K_DWAIT;
    else if (whole)        e_kind = K_FREEZE;
    else if (ds)           e_kind = K_BUB;
    else                   e_kind = K_NORM;
    case (e_kind)
      K_EXC:   en = {3'b111, {3{dok}}, 1'b0};
      K_DGO:   en = 7'b000_111_0;
      K_BUB:   en = 7'b001_111_1;
      K_NORM:  en = 7'b111_111_0;
      default: en = 7'b000_000_0;
    endcase
    exp = {en, f[1], f[0], ds, (e_kind == K_DGO || e_kind == K_DWAIT || e_kind == K_FREEZE),
           (m_cnt == 3)};
  endtask

  task automatic model_update();
    inf_t nq[$];
    foreach (q[i]) begin
      inf_t e;
      e = q[i];
      if (e_kind == K_EXC && !dok) begin
        if (e.stg != 1 && !kill[e.stg-1]) nq.push_back(e);
      end else if (e_kind == K_EXC || e_kind == K_DGO || e_kind == K_BUB || e_kind == K_NORM) begin
        if (e.stg < 4 && !(e_kind == K_EXC && kill[e.stg-1])) begin
          e.stg++;
          nq.push_back(e);
        end
      end else begin
        nq.push_back(e);
      end
    end
    if (e_kind == K_NORM && id_valid && id_rfwr && id_rd != 0)
      nq.push_back('{rd: int'(id_rd), rdy: int'(id_rdy), stg: 1});
    q = nq;
    m_cnt = (m_mode == 0) ? 0 : ((m_cnt == 3) ? 3 : m_cnt + 1);
    case (e_kind)
      K_EXC:    m_mode = dok ? 0 : 2;
      K_DWAIT:  m_mode = 2;
      K_FREEZE: m_mode = 1;
      default:  m_mode = 0;
    endcase
  endtask

  task automatic idle();
    id_valid = 0; id_rfwr = 0; id_rd = 0; id_rdy = 3'd1; id_src = 0;
    used = 0; late = 2'b11; ext = 0; whole = 0; exc = 0; kill = 0; dok = 1;
  endtask

  task automatic issue(input int rd, input int rdy);
    id_valid = 1; id_rfwr = 1; id_rd = 5'(rd); id_rdy = 3'(rdy);
  endtask

  task automatic consume(input int s0, input int s1, input logic [1:0] u, input logic [1:0] l);
    id_valid = 1; id_src = {5'(s1), 5'(s0)}; used = u; late = l;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (5) begin settle(); tick(); end
  endtask

  task automatic test_reset();
    idle();
    settle();
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL reset_model obs=%h exp=%h", obs, exp); end
    n_cmp++;
    if (obs !== 16'b111_111_0_000000_0_0_0) begin n_bad++; $display("FAIL reset_const obs=%h exp=%h", obs, 16'hFC00); end
    tick();
  endtask

  task automatic test_alu_fwd();
    drain();
    idle(); issue(5, 1); settle(); tick();
    idle(); consume(5, 0, 2'b01, 2'b11); settle();
    n_cmp++;
    if (obs !== exp || o_fwd_sel[2:0] !== 3'd1 || o_data_stall !== 1'b0) begin
      n_bad++; $display("FAIL alu_late obs=%h exp=%h fwd=%0d req=1", obs, exp, o_fwd_sel[2:0]);
    end
    tick();
    idle(); issue(5, 1); settle(); tick();
    idle(); consume(5, 0, 2'b01, 2'b10); settle();
    n_cmp++;
    if (obs !== exp || {o_data_stall, o_bubble, o_pc_wr} !== 3'b110) begin
      n_bad++; $display("FAIL alu_branch_stall obs=%h exp=%h stall/bub/pc=%b req=110", obs, exp, {o_data_stall, o_bubble, o_pc_wr});
    end
    tick();
    settle();
    n_cmp++;
    if (obs !== exp || o_fwd_sel[2:0] !== 3'd2 || o_data_stall !== 1'b0) begin
      n_bad++; $display("FAIL alu_branch_fwd obs=%h exp=%h fwd=%0d req=2", obs, exp, o_fwd_sel[2:0]);
    end
    tick();
  endtask

  task automatic test_load_use();
    for (int br = 0; br < 2; br++) begin
      int n, want;
      logic done;
      want = (br == 0) ? 2 : 3;
      drain();
      idle(); issue(7, 3); settle(); tick();
      idle(); consume(7, 0, 2'b01, (br == 0) ? 2'b11 : 2'b10);
      n = 0;
      done = 0;
      for (int c = 0; c < 6 && !done; c++) begin
        settle();
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL load_use_cyc br=%0d c=%0d obs=%h exp=%h", br, c, obs, exp); end
        if (o_data_stall) n++;
        else begin
          done = 1;
          n_cmp++;
          if (o_fwd_sel[2:0] !== 3'(want + 1)) begin n_bad++; $display("FAIL load_use_fwd br=%0d fwd=%0d req=%0d", br, o_fwd_sel[2:0], want + 1); end
        end
        tick();
      end
      n_cmp++;
      if (!done || n != want) begin n_bad++; $display("FAIL load_use_stalls br=%0d got=%0d req=%0d", br, n, want); end
    end
  endtask

  task automatic test_youngest();
    drain();
    idle(); issue(7, 1); settle(); tick();
    idle(); issue(7, 1); settle(); tick();
    idle(); issue(0, 1); settle(); tick();
    idle(); consume(0, 7, 2'b11, 2'b11); settle();
    n_cmp++;
    if (obs !== exp || o_fwd_sel !== {3'd2, 3'd0}) begin
      n_bad++; $display("FAIL youngest_r0 obs=%h exp=%h fwd=%h req=10", obs, exp, o_fwd_sel);
    end
    tick();
  endtask

  task automatic test_whole_hold();
    drain();
    idle(); issue(3, 2); settle(); tick();
    idle(); whole = 1;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_cmp++;
      if (obs !== exp || {o_pc_wr, o_if_id_wr, o_id_ex_wr, o_stage_wr} !== 6'b0) begin
        n_bad++; $display("FAIL whole_hold c=%0d obs=%h exp=%h", c, obs, exp);
      end
      tick();
    end
    idle(); consume(3, 0, 2'b01, 2'b11);
    for (int c = 0; c < 3; c++) begin
      settle();
      n_cmp++;
      if (obs !== exp || (c == 0 && o_fwd_sel[2:0] !== 3'd1)) begin
        n_bad++; $display("FAIL whole_release c=%0d obs=%h exp=%h", c, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_exc_drain();
    drain();
    for (int r = 1; r <= 4; r++) begin idle(); issue(r, 1); settle(); tick(); end
    idle(); exc = 1; kill = 4'b0011; dok = 0; settle();
    n_cmp++;
    if (obs !== exp || {o_pc_wr, o_stage_wr, o_bubble} !== 5'b1_000_0) begin
      n_bad++; $display("FAIL exc_nodok obs=%h exp=%h", obs, exp);
    end
    tick();
    idle(); dok = 0;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_cmp++;
      if (obs !== exp || {o_pc_wr, o_if_id_wr, o_id_ex_wr, o_stage_wr} !== 6'b0) begin
        n_bad++; $display("FAIL drain_wait c=%0d obs=%h exp=%h", c, obs, exp);
      end
      tick();
    end
    idle(); settle();
    n_cmp++;
    if (obs !== exp || o_stage_wr !== 3'b111 || o_pc_wr !== 1'b0) begin
      n_bad++; $display("FAIL drain_go obs=%h exp=%h", obs, exp);
    end
    tick();
    idle(); consume(3, 2, 2'b11, 2'b11); settle();
    n_cmp++;
    if (obs !== exp || o_fwd_sel !== {3'd4, 3'd0}) begin
      n_bad++; $display("FAIL exc_kill_fwd obs=%h exp=%h fwd=%h req=20", obs, exp, o_fwd_sel);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_rfwr  = $urandom_range(0, 1);
      id_rd    = 5'($urandom_range(0, 7));
      id_rdy   = 3'($urandom_range(1, 3));
      id_src   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      used     = 2'($urandom_range(0, 3));
      late     = 2'($urandom_range(0, 3));
      ext      = ($urandom_range(0, 7) == 0);
      whole    = ($urandom_range(0, 9) == 0);
      exc      = ($urandom_range(0, 19) == 0);
      kill     = 4'($urandom_range(0, 15));
      dok      = ($urandom_range(0, 3) != 0);
      settle();
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL random c=%0d obs=%h exp=%h", c, obs, exp); end
      tick();
    end
  endtask

  task automatic test_timeout_reset();
    drain();
    idle(); issue(5, 1); settle(); tick();
    idle(); whole = 1;
    for (int c = 0; c < 6; c++) begin
      settle();
      n_cmp++;
      if (obs !== exp || (c >= 4 && o_stall_timeout !== 1'b1)) begin
        n_bad++; $display("FAIL timeout c=%0d obs=%h exp=%h to=%b", c, obs, exp, o_stall_timeout);
      end
      tick();
    end
    whole = 0;
    rst_n = 0;
    #2;
    model_reset();
    model_eval();
    n_cmp++;
    if (obs !== exp || o_stall_timeout !== 1'b0) begin
      n_bad++; $display("FAIL async_reset obs=%h exp=%h", obs, exp);
    end
    #1 rst_n = 1;
    idle(); consume(5, 0, 2'b01, 2'b11); settle();
    n_cmp++;
    if (obs !== exp || o_fwd_sel !== 6'd0) begin
      n_bad++; $display("FAIL reset_shadow obs=%h exp=%h fwd=%h req=0", obs, exp, o_fwd_sel);
    end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_youngest();
    test_whole_hold();
    test_exc_drain();
    test_random();
    test_timeout_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
